i2s_mask: RTL and testbench

I2S_MASK -- requirements
Module: i2s_mask

---
 rtl/i2s_mask_pkg.sv | 29 ++
 rtl/i2s_mask_if.sv | 24 ++
 rtl/i2s_frame_counter.sv | 73 +++++++
 rtl/i2s_mask.sv | 102 ++++++++++
 tb/tb_i2s_mask.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2s_mask_pkg.sv
// Shared geometry defaults, counter widths and latch-sequencer state type
// for the tile-masking I2S LED panel receiver.
package i2s_mask_pkg;

    localparam int unsigned COLS_DEF    = 8;
    localparam int unsigned TILES_X_DEF = 16;
    localparam int unsigned ROWS_DEF    = 64;
    localparam int unsigned TILES_Y_DEF = 16;

    localparam int unsigned ADDR_W    = 4;
    localparam int unsigned ROW_NUM_W = 6;

    // Counter width for a dimension of n positions; never narrower than 1 bit.
    function automatic int unsigned cw(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned BIT_W = cw(COLS_DEF);
    localparam int unsigned TX_W  = cw(TILES_X_DEF);
    localparam int unsigned ROW_W = cw(ROWS_DEF);
    localparam int unsigned TY_W  = cw(TILES_Y_DEF);

    typedef enum logic [1:0] {
        LS_DARK,
        LS_LATCH,
        LS_SHOW
    } lat_state_e;

endpackage

// File: rtl/i2s_mask_if.sv
// Panel-side bundle: serial frame input, static tile address and LED driver outputs.
interface i2s_mask_if;
    import i2s_mask_pkg::*;

    logic                 i2s_data;
    logic [ADDR_W-1:0]    addr_x;
    logic [ADDR_W-1:0]    addr_y;
    logic [ROW_NUM_W-1:0] row_num;
    logic                 led_data;
    logic                 led_clk;
    logic                 led_lat;
    logic                 led_oe;

    modport master (
        output i2s_data, addr_x, addr_y,
        input  row_num, led_data, led_clk, led_lat, led_oe
    );

    modport slave (
        input  i2s_data, addr_x, addr_y,
        output row_num, led_data, led_clk, led_lat, led_oe
    );

endinterface

// File: rtl/i2s_frame_counter.sv
// Position of the current serial bit within the frame: bit, tile column,
// row and tile row, carried in that order with a gapless wrap at frame end.
module i2s_frame_counter
    import i2s_mask_pkg::*;
#(
    parameter int unsigned COLS    = COLS_DEF,
    parameter int unsigned TILES_X = TILES_X_DEF,
    parameter int unsigned ROWS    = ROWS_DEF,
    parameter int unsigned TILES_Y = TILES_Y_DEF,
    localparam int unsigned BW = cw(COLS),
    localparam int unsigned XW = cw(TILES_X),
    localparam int unsigned RW = cw(ROWS),
    localparam int unsigned YW = cw(TILES_Y)
) (
    input  logic          clk,
    input  logic          rst,
    output logic [BW-1:0] bit_idx,
    output logic [XW-1:0] tile_x,
    output logic [RW-1:0] row,
    output logic [YW-1:0] tile_y,
    output logic          last_bit
);

    localparam logic [BW-1:0] BIT_LAST = BW'(COLS - 1);
    localparam logic [XW-1:0] TX_LAST  = XW'(TILES_X - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [YW-1:0] TY_LAST  = YW'(TILES_Y - 1);

    logic [BW-1:0] bit_q, bit_d;
    logic [XW-1:0] tx_q, tx_d;
    logic [RW-1:0] row_q, row_d;
    logic [YW-1:0] ty_q, ty_d;

    always_comb begin
        bit_d = bit_q + 1'b1;
        tx_d  = tx_q;
        row_d = row_q;
        ty_d  = ty_q;
        if (bit_q == BIT_LAST) begin
            bit_d = '0;
            tx_d  = tx_q + 1'b1;
            if (tx_q == TX_LAST) begin
                tx_d  = '0;
                row_d = row_q + 1'b1;
                if (row_q == ROW_LAST) begin
                    row_d = '0;
                    ty_d  = (ty_q == TY_LAST) ? '0 : ty_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_q <= '0;
            tx_q  <= '0;
            row_q <= '0;
            ty_q  <= '0;
        end else begin
            bit_q <= bit_d;
            tx_q  <= tx_d;
            row_q <= row_d;
            ty_q  <= ty_d;
        end
    end

    assign bit_idx  = bit_q;
    assign tile_x   = tx_q;
    assign row      = row_q;
    assign tile_y   = ty_q;
    assign last_bit = (bit_q == BIT_LAST);

endmodule

// File: rtl/i2s_mask.sv
// Extracts this panel's tile from the serial frame stream and drives the LED
// shift register: gated shift clock, one-cycle latch strobe and blanking.
module i2s_mask
    import i2s_mask_pkg::*;
#(
    parameter int unsigned COLS    = COLS_DEF,
    parameter int unsigned TILES_X = TILES_X_DEF,
    parameter int unsigned ROWS    = ROWS_DEF,
    parameter int unsigned TILES_Y = TILES_Y_DEF
) (
    input  logic         i2s_clk,
    input  logic         rst,
    i2s_mask_if.slave    bus
);

    localparam int unsigned BW = cw(COLS);
    localparam int unsigned XW = cw(TILES_X);
    localparam int unsigned RW = cw(ROWS);
    localparam int unsigned YW = cw(TILES_Y);

    logic [BW-1:0] bit_idx;
    logic [XW-1:0] tile_x;
    logic [RW-1:0] row;
    logic [YW-1:0] tile_y;
    logic          last_bit;

    i2s_frame_counter #(
        .COLS    (COLS),
        .TILES_X (TILES_X),
        .ROWS    (ROWS),
        .TILES_Y (TILES_Y)
    ) u_cnt (
        .clk      (i2s_clk),
        .rst      (rst),
        .bit_idx  (bit_idx),
        .tile_x   (tile_x),
        .row      (row),
        .tile_y   (tile_y),
        .last_bit (last_bit)
    );

    logic [ADDR_W-1:0]    ax_q, ax_d, ay_q, ay_d;
    logic                 led_data_q, led_data_d;
    logic                 shift_q, shift_d;
    logic                 pend_q, pend_d;
    logic [RW-1:0]        prow_q, prow_d;
    logic [ROW_NUM_W-1:0] row_num_q, row_num_d;
    lat_state_e           state_q, state_d;
    logic                 match;

    // The address is sampled only on a tile's first bit and held for the rest
    // of it, so a mid-tile address change can never split a tile.
    always_comb begin
        ax_d       = (bit_idx == '0) ? bus.addr_x : ax_q;
        ay_d       = (bit_idx == '0) ? bus.addr_y : ay_q;
        match      = (ADDR_W'(tile_x) == ax_d) && (ADDR_W'(tile_y) == ay_d);
        led_data_d = match ? bus.i2s_data : led_data_q;
        shift_d    = match;
        pend_d     = match && last_bit;
        prow_d     = row;
        row_num_d  = pend_q ? ROW_NUM_W'(prow_q) : row_num_q;
    end

    always_comb begin
        state_d = state_q;
        if (pend_q) begin
            state_d = LS_LATCH;
        end else if (state_q == LS_LATCH) begin
            state_d = LS_SHOW;
        end
    end

    always_ff @(posedge i2s_clk or posedge rst) begin
        if (rst) begin
            ax_q       <= '0;
            ay_q       <= '0;
            led_data_q <= 1'b0;
            shift_q    <= 1'b0;
            pend_q     <= 1'b0;
            prow_q     <= '0;
            row_num_q  <= '0;
            state_q    <= LS_DARK;
        end else begin
            ax_q       <= ax_d;
            ay_q       <= ay_d;
            led_data_q <= led_data_d;
            shift_q    <= shift_d;
            pend_q     <= pend_d;
            prow_q     <= prow_d;
            row_num_q  <= row_num_d;
            state_q    <= state_d;
        end
    end

    // shift_q only changes while i2s_clk is high, so the AND cannot glitch.
    assign bus.led_clk  = shift_q & ~i2s_clk;
    assign bus.led_data = led_data_q;
    assign bus.row_num  = row_num_q;
    assign bus.led_lat  = (state_q == LS_LATCH);
    assign bus.led_oe   = (state_q != LS_SHOW);

endmodule

// File: tb/tb_i2s_mask.sv
// Directed and random stimulus for i2s_mask: a default-geometry panel and a
// small-geometry panel share the stream and are checked against a positional model.
module tb_i2s_mask;

    logic i2s_clk = 1'b0;
    logic rst     = 1'b0;

    always #5 i2s_clk = ~i2s_clk;

    i2s_mask_if bus0 ();
    i2s_mask_if bus1 ();

    i2s_mask dut0 (
        .i2s_clk (i2s_clk),
        .rst     (rst),
        .bus     (bus0)
    );

    i2s_mask #(
        .COLS    (8),
        .TILES_X (4),
        .ROWS    (4),
        .TILES_Y (4)
    ) dut1 (
        .i2s_clk (i2s_clk),
        .rst     (rst),
        .bus     (bus1)
    );

    int n_assert = 0;
    int n_fail   = 0;

    logic        dq [$];
    logic [15:0] aq [$];
    int          cyc;

    logic       exp_ld  [2];
    logic       exp_sh  [2];
    logic       exp_lat [2];
    logic       exp_oe  [2];
    logic [5:0] exp_row [2];
    bit         seen    [2];

    int   lat_cnt [2];
    int   clk_cnt [2];
    int   oe_low  [2];
    int   lat_rows0 [$];
    int   lat_rows1 [$];
    int   lat_cyc0  [$];
    int   lat_cyc1  [$];
    logic [7:0] seq0;

    function automatic int geo_tx(input int k);
        return (k == 0) ? 16 : 4;
    endfunction

    function automatic int geo_rows(input int k);
        return (k == 0) ? 64 : 4;
    endfunction

    function automatic int geo_ty(input int k);
        return (k == 0) ? 16 : 4;
    endfunction

    function automatic int geo_row(input int k, input int n);
        return (n / (8 * geo_tx(k))) % geo_rows(k);
    endfunction

    // Does stream bit n land in this panel's tile, using the address seen at the tile's first bit?
    function automatic logic m_match(input int k, input int n);
        int          s;
        int          tx;
        int          ty;
        int          ax;
        int          ay;
        logic [15:0] a;
        s  = n - (n % 8);
        tx = (n / 8) % geo_tx(k);
        ty = (n / (8 * geo_tx(k) * geo_rows(k))) % geo_ty(k);
        a  = aq[s];
        ax = (k == 0) ? int'(a[15:12]) : int'(a[7:4]);
        ay = (k == 0) ? int'(a[11:8])  : int'(a[3:0]);
        return (tx == ax) && (ty == ay);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
        end
    endtask

    task automatic check_dut(input int k, input logic ld, input logic lat, input logic oe,
                             input logic [5:0] rn, input logic lclk);
        chk($sformatf("d%0d_led_data@%0d", k, cyc), ld, exp_ld[k]);
        chk($sformatf("d%0d_led_lat@%0d", k, cyc), lat, exp_lat[k]);
        chk($sformatf("d%0d_led_oe@%0d", k, cyc), oe, exp_oe[k]);
        chk($sformatf("d%0d_row_num@%0d", k, cyc), rn, exp_row[k]);
        chk($sformatf("d%0d_led_clk_hi@%0d", k, cyc), lclk, 1'b0);
    endtask

    task automatic clear_stats();
        for (int k = 0; k < 2; k++) begin
            lat_cnt[k] = 0;
            clk_cnt[k] = 0;
            oe_low[k]  = 0;
        end
        lat_rows0.delete();
        lat_rows1.delete();
        lat_cyc0.delete();
        lat_cyc1.delete();
        seq0 = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        dq.delete();
        aq.delete();
        cyc = 0;
        for (int k = 0; k < 2; k++) begin
            exp_ld[k]  = 1'b0;
            exp_sh[k]  = 1'b0;
            exp_lat[k] = 1'b0;
            exp_oe[k]  = 1'b1;
            exp_row[k] = '0;
            seen[k]    = 1'b0;
        end
        check_dut(0, bus0.led_data, bus0.led_lat, bus0.led_oe, bus0.row_num, bus0.led_clk);
        check_dut(1, bus1.led_data, bus1.led_lat, bus1.led_oe, bus1.row_num, bus1.led_clk);
        @(negedge i2s_clk);
        #1;
        rst = 1'b0;
        clear_stats();
    endtask

    task automatic step(input logic d);
        bus0.i2s_data = d;
        bus1.i2s_data = d;
        dq.push_back(d);
        aq.push_back({bus0.addr_x, bus0.addr_y, bus1.addr_x, bus1.addr_y});
        @(posedge i2s_clk);
        #1;
        cyc++;
        for (int k = 0; k < 2; k++) begin
            exp_sh[k] = m_match(k, cyc - 1);
            if (exp_sh[k]) exp_ld[k] = dq[cyc - 1];
            exp_lat[k] = (cyc >= 2) && m_match(k, cyc - 2) && ((cyc - 2) % 8 == 7);
            if (exp_lat[k]) begin
                exp_row[k] = 6'(geo_row(k, cyc - 2));
                seen[k]    = 1'b1;
            end
            exp_oe[k] = exp_lat[k] || !seen[k];
        end
        check_dut(0, bus0.led_data, bus0.led_lat, bus0.led_oe, bus0.row_num, bus0.led_clk);
        check_dut(1, bus1.led_data, bus1.led_lat, bus1.led_oe, bus1.row_num, bus1.led_clk);
        if (bus0.led_lat === 1'b1) begin
            lat_cnt[0]++;
            lat_rows0.push_back(int'(bus0.row_num));
            lat_cyc0.push_back(cyc);
        end
        if (bus1.led_lat === 1'b1) begin
            lat_cnt[1]++;
            lat_rows1.push_back(int'(bus1.row_num));
            lat_cyc1.push_back(cyc);
        end
        if (bus0.led_oe === 1'b0) oe_low[0]++;
        if (bus1.led_oe === 1'b0) oe_low[1]++;
        @(negedge i2s_clk);
        #1;
        chk($sformatf("d0_led_clk_lo@%0d", cyc), bus0.led_clk, exp_sh[0]);
        chk($sformatf("d1_led_clk_lo@%0d", cyc), bus1.led_clk, exp_sh[1]);
        if (bus0.led_clk === 1'b1) begin
            clk_cnt[0]++;
            seq0 = {seq0[6:0], bus0.led_data};
        end
        if (bus1.led_clk === 1'b1) clk_cnt[1]++;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pat;
        bus0.i2s_data = 1'b0;
        bus1.i2s_data = 1'b0;
        bus0.addr_x = 4'd0;
        bus0.addr_y = 4'd0;
        bus1.addr_x = 4'd0;
        bus1.addr_y = 4'd0;
        #1;

        // Tile (0,0): pattern shifted out in stream order, latched one cycle later.
        do_reset();
        pat = 8'b10110010;
        for (int i = 0; i < 8; i++) step(pat[7 - i]);
        step(1'b0);
        step(1'b1);
        chk("p1_clk_pulses", clk_cnt[0], 8);
        chk("p1_data_seq", seq0, 8'hB2);
        chk("p1_lat_count", lat_cnt[0], 1);
        chk("p1_lat_cycle", (lat_cyc0.size() > 0) ? lat_cyc0[0] : -1, 9);
        chk("p1_row_num", (lat_rows0.size() > 0) ? lat_rows0[0] : -1, 0);

        // Tile (1,1) is never reached within the first tile row of the frame.
        bus0.addr_x = 4'd1;
        bus0.addr_y = 4'd1;
        do_reset();
        for (int i = 0; i < 8042; i++) step(1'($urandom_range(1, 0)));
        chk("p2_clk_pulses", clk_cnt[0], 0);
        chk("p2_lat_count", lat_cnt[0], 0);
        chk("p2_oe_low_cycles", oe_low[0], 0);

        // Tile (1,0) over three lines.
        bus0.addr_x = 4'd1;
        bus0.addr_y = 4'd0;
        do_reset();
        for (int i = 0; i < 3 * 128; i++) step(1'($urandom_range(1, 0)));
        chk("p3_lat_count", lat_cnt[0], 3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("p3_lat_row%0d", i), (lat_rows0.size() > i) ? lat_rows0[i] : -1, i);
            chk($sformatf("p3_lat_cyc%0d", i), (lat_cyc0.size() > i) ? lat_cyc0[i] : -1, 17 + 128 * i);
        end

        // Reset in the middle of a matched tile aborts it; the next tile is normal.
        bus0.addr_x = 4'd0;
        bus0.addr_y = 4'd0;
        do_reset();
        for (int i = 0; i < 4; i++) step(1'($urandom_range(1, 0)));
        chk("p4_lat_before_reset", lat_cnt[0], 0);
        chk("p4_clk_before_reset", clk_cnt[0], 4);
        do_reset();
        for (int i = 0; i < 10; i++) step(1'($urandom_range(1, 0)));
        chk("p4_lat_after_reset", lat_cnt[0], 1);
        chk("p4_clk_after_reset", clk_cnt[0], 8);

        // Address switched mid-tile: current tile finishes, new address from the next tile.
        bus0.addr_x = 4'd1;
        do_reset();
        for (int i = 0; i < 11; i++) step(1'($urandom_range(1, 0)));
        bus0.addr_x = 4'd2;
        for (int i = 0; i < 15; i++) step(1'($urandom_range(1, 0)));
        chk("p5_lat_count", lat_cnt[0], 2);
        chk("p5_clk_pulses", clk_cnt[0], 16);
        chk("p5_lat_cyc0", (lat_cyc0.size() > 0) ? lat_cyc0[0] : -1, 17);
        chk("p5_lat_cyc1", (lat_cyc0.size() > 1) ? lat_cyc0[1] : -1, 25);

        // Small panel: last tile of the frame, then wrap straight into tile (0,0).
        bus1.addr_x = 4'd3;
        bus1.addr_y = 4'd3;
        do_reset();
        for (int i = 0; i < 506; i++) step(1'($urandom_range(1, 0)));
        bus1.addr_x = 4'd0;
        bus1.addr_y = 4'd0;
        for (int i = 0; i < 16; i++) step(1'($urandom_range(1, 0)));
        chk("p6_lat_count", lat_cnt[1], 5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("p6_lat_row%0d", i), (lat_rows1.size() > i) ? lat_rows1[i] : -1, (i < 4) ? i : 0);
        end
        chk("p6_last_frame_lat_cyc", (lat_cyc1.size() > 3) ? lat_cyc1[3] : -1, 513);
        chk("p6_wrap_lat_cyc", (lat_cyc1.size() > 4) ? lat_cyc1[4] : -1, 521);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
